busca_instrucao: RTL and testbench

- Instruction fetch/sequencer for the full nibble processor. Sits directly upstream of controle_central.
- Holds the program counter and the instruction register (IR), and drives op plus the latched overflow flag into the central control.
- Consumes ended from the central control to stop the program.
- Reads a combinational instruction memory: 16 words of 8 bits each.

---
 rtl/busca_pkg.sv | 31 +++
 rtl/busca_instrucao_contador_pc.sv | 30 +++
 rtl/busca_instrucao.sv | 131 +++++++++++++
 tb/tb_busca_instrucao.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/busca_pkg.sv
`default_nettype none
// ============================================================================
// Module      : busca_pkg
// Description : Shared types and constants for the instruction fetch block:
//               sequencer state encoding, default widths, instruction field
//               positions and the end-of-program opcode.
// Revision    : 1.0  initial release
// ============================================================================
package busca_pkg;

    localparam int PC_WIDTH_DEF    = 4;
    localparam int INSTR_WIDTH_DEF = 8;
    localparam int OP_WIDTH_DEF    = 3;

    // Instruction layout: [7:5] opcode, [4] reserved, [3:0] operand
    localparam int OP_MSB      = 7;
    localparam int OP_LSB      = 5;
    localparam int OPERAND_MSB = 3;

    localparam logic [2:0] OP_FIM = 3'b111;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        EXEC      = 3'd2,
        HALT      = 3'd3,
        STEP_WAIT = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/busca_instrucao_contador_pc.sv
`default_nettype none
// ============================================================================
// Module      : contador_pc
// Description : WIDTH-bit program counter. Increments by one when inc is
//               high, wrapping modulo 2^WIDTH without any flag.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low clear
//               inc   - increment enable
//               count - current counter value
// Revision    : 1.0  initial release
// ============================================================================
module contador_pc #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;   // natural overflow gives the wrap
        end
    end

endmodule
`default_nettype wire

// File: rtl/busca_instrucao.sv
`default_nettype none
// ============================================================================
// Module      : busca_instrucao
// Description : Instruction fetch / sequencer. Holds the program counter and
//               the instruction fields, feeds op, operand and the latched
//               overflow flag to the central control, and stops when the
//               central control reports end of program. One instruction is
//               executed every two cycles (FETCH, EXEC).
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               start           - begin execution from IDLE
//               step            - (BUSCA_SINGLE_STEP_EN only) release from
//                                 STEP_WAIT to the next fetch
//               imem_addr/data  - combinational instruction memory port
//               alu_ovf         - raw adder overflow, latched at EXEC
//               ended           - end of program from central control
//               op, operand     - instruction fields, qualify with ir_valid
//               ovf             - registered overflow flag
//               ir_valid        - high during EXEC
//               halted          - program finished
//               pc              - program counter (debug)
// Build macro : BUSCA_SINGLE_STEP_EN adds the step input and STEP_WAIT state
// Revision    : 1.0  initial release
// ============================================================================
module busca_instrucao
    import busca_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int OP_WIDTH    = OP_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
`ifdef BUSCA_SINGLE_STEP_EN
    input  logic                   step,
`endif
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    input  logic                   alu_ovf,
    input  logic                   ended,
    output logic [OP_WIDTH-1:0]    op,
    output logic                   ovf,
    output logic [3:0]             operand,
    output logic                   ir_valid,
    output logic                   halted,
    output logic [PC_WIDTH-1:0]    pc
);

    state_t state;
    logic   pc_inc;
    logic   unused_reserved_bit;

    // Bit 4 of the instruction is reserved; it is never stored.
    assign unused_reserved_bit = imem_data[4];

    // The counter advances only on the EXEC edge of a non-terminating
    // instruction, so a halted program keeps pointing at its last opcode.
    assign pc_inc    = (state == EXEC) && !ended;
    assign imem_addr = pc;

    contador_pc #(
        .WIDTH (PC_WIDTH)
    ) u_contador_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pc_inc),
        .count (pc)
    );

    // Sequencer with registered outputs: ir_valid/halted are set on the
    // edge that enters EXEC/HALT so they line up with the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op       <= '0;
            operand  <= '0;
            ovf      <= 1'b0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FETCH;
                    end
                end

                FETCH: begin
                    op       <= imem_data[OP_MSB:OP_LSB];
                    operand  <= imem_data[OPERAND_MSB:0];
                    ir_valid <= 1'b1;
                    state    <= EXEC;
                end

                EXEC: begin
                    ovf      <= alu_ovf;   // overwritten every instruction
                    ir_valid <= 1'b0;
                    if (ended) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
`ifdef BUSCA_SINGLE_STEP_EN
                        state <= STEP_WAIT;
`else
                        state <= FETCH;
`endif
                    end
                end

                HALT: begin
                    state <= HALT;
                end

`ifdef BUSCA_SINGLE_STEP_EN
                STEP_WAIT: begin
                    if (step) begin
                        state <= FETCH;
                    end
                end
`endif

                default: begin
                    state    <= IDLE;
                    ir_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_busca_instrucao.sv
`default_nettype none
// ============================================================================
// Module      : tb_busca_instrucao
// Description : Scoreboard bench for busca_instrucao. Programs are placed in
//               a testbench instruction memory; a reference walk of the
//               program produces the expected (pc, op, operand) stream and a
//               monitor compares every EXEC cycle, the overflow latch and
//               the halt behaviour.
// Revision    : 1.0  initial release
// ============================================================================
module tb_busca_instrucao;
    import busca_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] imem_addr;
    logic [7:0] imem_data;
    logic       alu_ovf;
    logic       ended;
    logic [2:0] op;
    logic       ovf;
    logic [3:0] operand;
    logic       ir_valid;
    logic       halted;
    logic [3:0] pc;
`ifdef BUSCA_SINGLE_STEP_EN
    logic       step = 1'b1;
`endif

    logic [7:0] imem [16];

    typedef struct {
        logic [3:0] pc;
        logic [2:0] op;
        logic [3:0] operand;
    } exp_t;

    exp_t q[$];

    int   checks      = 0;
    int   failures    = 0;
    int   popped_cnt  = 0;
    logic exp_ovf     = 1'b0;
    logic exp_halted  = 1'b0;
    logic halt_next   = 1'b0;
    logic [3:0] halt_pc = '0;

    always #5 clk = ~clk;

    assign imem_data = imem[imem_addr];
    // Central control model: signals end while an end opcode is executing
    assign ended = ir_valid && (op == OP_FIM);

    busca_instrucao dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
`ifdef BUSCA_SINGLE_STEP_EN
        .step      (step),
`endif
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .alu_ovf   (alu_ovf),
        .ended     (ended),
        .op        (op),
        .ovf       (ovf),
        .operand   (operand),
        .ir_valid  (ir_valid),
        .halted    (halted),
        .pc        (pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int a, input logic [7:0] w);
        exp_t e;
        e.pc      = a[3:0];
        e.op      = w[7:5];
        e.operand = w[3:0];
        return e;
    endfunction

    // Reference: walk the program from address 0 until the end opcode.
    task automatic push_program();
        int a = 0;
        for (int n = 0; n < 64; n++) begin
            q.push_back(mk(a, imem[a]));
            if (imem[a][7:5] == OP_FIM) break;
            a = (a + 1) % 16;
        end
    endtask

    function automatic logic [7:0] rand_non_end();
        logic [7:0] w;
        w = 8'($urandom);
        if (w[7:5] == OP_FIM) w[7:5] = 3'($urandom_range(0, 6));
        return w;
    endfunction

    // Random overflow from the "datapath", changed away from both edges
    initial begin
        alu_ovf = 1'b0;
        forever begin
            @(posedge clk);
            #2 alu_ovf = 1'($urandom_range(0, 1));
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_ovf    = 1'b0;
            exp_halted = 1'b0;
            halt_next  = 1'b0;
        end else begin
            if (halt_next) begin
                exp_halted = 1'b1;
                halt_next  = 1'b0;
                chk("halt_pc", pc, halt_pc);
            end
            chk("halted", halted, exp_halted);
            chk("ovf", ovf, exp_ovf);
            chk("imem_addr", imem_addr, pc);
            if (ir_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_exec", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    popped_cnt++;
                    chk("exec_pc", pc, e.pc);
                    chk("op", op, e.op);
                    chk("operand", operand, e.operand);
                    exp_ovf = alu_ovf;
                    if (e.op == OP_FIM) begin
                        halt_next = 1'b1;
                        halt_pc   = e.pc;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(q.size() == 0 && exp_halted) && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_popped(input int target, input string name);
        int n = 0;
        while (popped_cnt < target && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic check_halt_ignores_start(input logic [3:0] hpc);
        pulse_start();
        repeat (4) @(posedge clk);
        #1;
        chk("halt_hold", {halted, ir_valid, pc}, {1'b1, 1'b0, hpc});
    endtask

    initial begin
        logic [7:0] new2;
        int k;
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 16; i++) imem[i] = 8'($urandom);

        // Reset values, then IDLE holds without start
        #3;
        chk("rst_outputs", {pc, op, operand, ovf, ir_valid, halted}, 0);
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("idle_hold", {ir_valid, halted, pc}, 0);
        end

        // Straight-line program
        imem[0] = 8'h25; imem[1] = 8'h43; imem[2] = 8'hE0;
        push_program();
        popped_cnt = 0;
        pulse_start();
        wait_done("straight");
        check_halt_ignores_start(4'd2);

        // Random programs with the end opcode at a random address
        for (int p = 0; p < 6; p++) begin
            do_reset();
            k = $urandom_range(0, 15);
            for (int i = 0; i < 16; i++) imem[i] = (i < k) ? rand_non_end() : 8'($urandom);
            imem[k] = {OP_FIM, 5'($urandom)};
            push_program();
            popped_cnt = 0;
            pulse_start();
            wait_done("random");
            check_halt_ignores_start(k[3:0]);
        end

        // Wrap-around: full pass, then end opcode patched in at address 2
        do_reset();
        for (int i = 0; i < 16; i++) imem[i] = rand_non_end();
        new2 = {OP_FIM, 5'($urandom)};
        for (int a = 0; a < 16; a++) q.push_back(mk(a, imem[a]));
        q.push_back(mk(0, imem[0]));
        q.push_back(mk(1, imem[1]));
        q.push_back(mk(2, new2));
        popped_cnt = 0;
        pulse_start();
        wait_popped(3, "wrap_first");
        imem[2] = new2;
        wait_popped(16, "wrap_pass");
        chk("wrap_pc", {pc, imem_addr}, 8'h00);
        wait_done("wrap");

        // Asynchronous reset in the middle of EXEC
        do_reset();
        for (int i = 0; i < 16; i++) imem[i] = rand_non_end();
        imem[10] = {OP_FIM, 5'($urandom)};
        push_program();
        popped_cnt = 0;
        pulse_start();
        wait_popped(3, "midrst");
        begin
            int n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!ir_valid && n < 20);
            if (n >= 20) chk("midrst_exec_timeout", 0, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pc", pc, 0);
        chk("midrst_fields", {op, operand, ovf}, 0);
        chk("midrst_flags", {ir_valid, halted}, 0);
        q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        push_program();
        popped_cnt = 0;
        pulse_start();
        wait_done("refetch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
